// File: rtl/rfile_pkg.sv
// rfile_pkg: shared constants and types for the scoreboarded register file.
// Revision 1.0
`default_nettype none

package rfile_pkg;

   localparam int REG_W_DEF  = 5;
   localparam int DATA_W_DEF = 32;
   localparam int REG_S_DEF  = 32;
   localparam int ZERO_REG   = 0;

   typedef logic [REG_W_DEF-1:0]  reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/rfile_sboard.sv
// rfile_sboard: per-register busy bits with issue-over-writeback priority and NRD lookups.
// Revision 1.0
`default_nettype none

module rfile_sboard
   import rfile_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int REG_S = REG_S_DEF,
   parameter int NRD   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iss_v,
   input  logic [REG_W-1:0]     iss_a,
   input  logic                 clr0,
   input  logic [REG_W-1:0]     clr_a0,
   input  logic                 clr1,
   input  logic [REG_W-1:0]     clr_a1,
   input  logic [NRD*REG_W-1:0] ra,
   output logic [NRD-1:0]       rbusy
);

   function automatic logic addr_ok(input logic [REG_W-1:0] a);
      return (32'(a) != 32'(ZERO_REG)) && (32'(a) < 32'(REG_S));
   endfunction

   logic [REG_S-1:0] busy;
   logic [REG_S-1:0] busy_nxt;

   // Set is applied after the clears so a newly issuing producer wins.
   always_comb begin
      busy_nxt = busy;
      if (clr0 && addr_ok(clr_a0)) busy_nxt[clr_a0] = 1'b0;
      if (clr1 && addr_ok(clr_a1)) busy_nxt[clr_a1] = 1'b0;
      if (iss_v && addr_ok(iss_a)) busy_nxt[iss_a] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_lookup
      logic [REG_W-1:0] a;
      assign a         = ra[gi*REG_W +: REG_W];
      assign rbusy[gi] = addr_ok(a) ? busy[a] : 1'b0;
   end

endmodule

`default_nettype wire

// File: rtl/rfile_sb.sv
// rfile_sb: NRD-read / 2-write register file with scoreboard; optional RFILE_BYPASS_EN write-to-read bypass.
// Revision 1.0
`default_nettype none

module rfile_sb
   import rfile_pkg::*;
#(
   parameter int REG_W  = REG_W_DEF,
   parameter int REG_S  = REG_S_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int NRD    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*REG_W-1:0]  ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        rbusy,
   input  logic                  we0,
   input  logic [REG_W-1:0]      wa0,
   input  logic [DATA_W-1:0]     wd0,
   input  logic                  we1,
   input  logic [REG_W-1:0]      wa1,
   input  logic [DATA_W-1:0]     wd1,
   input  logic                  iss_v,
   input  logic [REG_W-1:0]      iss_a,
   output logic                  wr_conf
);

   function automatic logic addr_ok(input logic [REG_W-1:0] a);
      return (32'(a) != 32'(ZERO_REG)) && (32'(a) < 32'(REG_S));
   endfunction

   logic [DATA_W-1:0] mem [REG_S];
   logic              conflict;
   logic              w0_ok;
   logic              w1_ok;
   logic [NRD-1:0]    sb_busy;

   assign conflict = we0 && we1 && (wa0 == wa1) && (32'(wa0) != 32'(ZERO_REG));
   assign w0_ok    = we0 && addr_ok(wa0);
   assign w1_ok    = we1 && addr_ok(wa1) && !conflict;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_S; i++) mem[i] <= '0;
         wr_conf <= 1'b0;
      end else begin
         if (w1_ok) mem[wa1] <= wd1;
         if (w0_ok) mem[wa0] <= wd0;
         wr_conf <= conflict;
      end
   end

   rfile_sboard #(
      .REG_W (REG_W),
      .REG_S (REG_S),
      .NRD   (NRD)
   ) u_sboard (
      .clk    (clk),
      .rst_n  (rst_n),
      .iss_v  (iss_v),
      .iss_a  (iss_a),
      .clr0   (we0),
      .clr_a0 (wa0),
      .clr1   (we1),
      .clr_a1 (wa1),
      .ra     (ra),
      .rbusy  (sb_busy)
   );

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [REG_W-1:0]  a;
      logic [DATA_W-1:0] arr_d;
      assign a     = ra[gi*REG_W +: REG_W];
      assign arr_d = addr_ok(a) ? mem[a] : '0;
`ifdef RFILE_BYPASS_EN
      logic hit0;
      logic hit1;
      logic iss_hit;
      assign hit0    = w0_ok && (wa0 == a);
      assign hit1    = we1 && addr_ok(wa1) && (wa1 == a);
      assign iss_hit = iss_v && (iss_a == a);
      // Bypass data must not leak out while the array is held in reset.
      assign rd[gi*DATA_W +: DATA_W] = !rst_n ? '0 :
                                       hit0   ? wd0 :
                                       hit1   ? wd1 : arr_d;
      assign rbusy[gi] = (hit0 || hit1) ? (iss_hit && rst_n) : sb_busy[gi];
`else
      assign rd[gi*DATA_W +: DATA_W] = arr_d;
      assign rbusy[gi]               = sb_busy[gi];
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_rfile_sb.sv
// tb_rfile_sb: directed vector table, reset/bypass corner cases and random traffic against a model.
`default_nettype none

module tb_rfile_sb;
   import rfile_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   reg_addr_t     ra0, ra1;
   logic [9:0]    ra;
   logic [63:0]   rd;
   logic [1:0]    rbusy;
   logic          we0, we1, iss_v;
   reg_addr_t     wa0, wa1, iss_a;
   reg_data_t     wd0, wd1;
   logic          wr_conf;

   always #5 clk = ~clk;
   assign ra = {ra1, ra0};

   rfile_sb dut (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .iss_v(iss_v), .iss_a(iss_a), .wr_conf(wr_conf)
   );

   typedef struct {
      logic we0; reg_addr_t wa0; reg_data_t wd0;
      logic we1; reg_addr_t wa1; reg_data_t wd1;
      logic iss_v; reg_addr_t iss_a;
      reg_addr_t ra0, ra1;
      reg_data_t e_rd0, e_rd1;
      logic [1:0] e_busy;
      logic e_conf;
   } vec_t;

   vec_t tbl[14];
   int   n_pass = 0;
   int   n_total = 0;

   reg_data_t m_mem [32];
   logic      m_busy[32];
   logic      m_conf;

   function automatic vec_t v(input logic [31:0] e0, a0, d0, e1, a1, d1, iv, ia,
                              r0, r1, x0, x1, xb, xc);
      vec_t r;
      r.we0 = e0[0]; r.wa0 = a0[4:0]; r.wd0 = d0;
      r.we1 = e1[0]; r.wa1 = a1[4:0]; r.wd1 = d1;
      r.iss_v = iv[0]; r.iss_a = ia[4:0];
      r.ra0 = r0[4:0]; r.ra1 = r1[4:0];
      r.e_rd0 = x0; r.e_rd1 = x1; r.e_busy = xb[1:0]; r.e_conf = xc[0];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic idle();
      we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0; iss_v = 0; iss_a = 0;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      m_conf = 1'b0;
   endtask

   // Expected read value: array contents, overridden by live write data when bypass is built in.
   function automatic reg_data_t m_rd(input reg_addr_t a);
      if (a == 0) return '0;
`ifdef RFILE_BYPASS_EN
      if (we0 && wa0 == a) return wd0;
      if (we1 && wa1 == a) return wd1;
`endif
      return m_mem[a];
   endfunction

   function automatic logic m_rb(input reg_addr_t a);
      if (a == 0) return 1'b0;
`ifdef RFILE_BYPASS_EN
      if ((we0 && wa0 == a) || (we1 && wa1 == a)) return iss_v && iss_a == a;
`endif
      return m_busy[a];
   endfunction

   // Port 1 is stored first so port 0 overwrites it on a same-address collision.
   task automatic m_clock();
      m_conf = we0 && we1 && wa0 == wa1 && wa0 != 0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we0) m_busy[wa0] = 1'b0;
      if (we1) m_busy[wa1] = 1'b0;
      if (iss_v && iss_a != 0) m_busy[iss_a] = 1'b1;
   endtask

   initial begin
      tbl[0]  = v(0, 0,0,    0, 0,0,   0,0, 1,31, 0,0,     0,0);
      tbl[1]  = v(1, 1,5,    0, 0,0,   0,0, 2,31, 0,0,     0,0);
      tbl[2]  = v(1, 0,999,  0, 0,0,   0,0, 1,0,  5,0,     0,0);
      tbl[3]  = v(0, 0,0,    0, 0,0,   0,0, 0,1,  0,5,     0,0);
      tbl[4]  = v(1,10,123,  1,10,77,  0,0, 1,0,  5,0,     0,0);
      tbl[5]  = v(1, 3,33,   1, 4,44,  0,0, 10,0, 123,0,   0,1);
      tbl[6]  = v(0, 0,0,    0, 0,0,   1,7, 3,4,  33,44,   0,0);
      tbl[7]  = v(0, 0,0,    1, 7,70,  1,7, 1,10, 5,123,   0,0);
      tbl[8]  = v(0, 0,0,    0, 0,0,   0,0, 7,0,  70,0,    1,0);
      tbl[9]  = v(0, 0,0,    1, 7,71,  0,0, 3,0,  33,0,    0,0);
      tbl[10] = v(0, 0,0,    0, 0,0,   1,0, 7,0,  71,0,    0,0);
      tbl[11] = v(0, 0,0,    0, 0,0,   0,0, 0,7,  0,71,    0,0);
      tbl[12] = v(1, 2,32'hDEADBEEF, 0,0,0, 1,2, 1,3, 5,33, 0,0);
      tbl[13] = v(0, 0,0,    0, 0,0,   0,0, 2,1,  32'hDEADBEEF,5, 1,0);

      rst_n = 1'b0; idle(); ra0 = 1; ra1 = 31;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
         we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
         iss_v = tbl[i].iss_v; iss_a = tbl[i].iss_a;
         ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
         #1;
         chk($sformatf("vec%0d rd0", i), rd[31:0], tbl[i].e_rd0);
         chk($sformatf("vec%0d rd1", i), rd[63:32], tbl[i].e_rd1);
         chk($sformatf("vec%0d rbusy", i), {30'd0, rbusy}, {30'd0, tbl[i].e_busy});
         chk($sformatf("vec%0d wr_conf", i), {31'd0, wr_conf}, {31'd0, tbl[i].e_conf});
         @(posedge clk); m_clock();
      end

      // Asynchronous reset between edges, then a write presented during reset must be lost.
      @(negedge clk); idle(); ra0 = 2; ra1 = 2;
      #1 chk("pre_reset rd0", rd[31:0], 32'hDEADBEEF);
      chk("pre_reset rbusy0", {31'd0, rbusy[0]}, 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("async_reset rd0", rd[31:0], 32'd0);
      chk("async_reset rbusy", {30'd0, rbusy}, 32'd0);
      chk("async_reset wr_conf", {31'd0, wr_conf}, 32'd0);
      we0 = 1; wa0 = 2; wd0 = 32'd1234;
      @(posedge clk); #1 rst_n = 1'b1; idle(); m_reset();
      #1 chk("write_in_reset rd0", rd[31:0], 32'd0);

      // Same-cycle read of the register being written.
      @(negedge clk); we0 = 1; wa0 = 5; wd0 = 32'd42; ra0 = 5; ra1 = 5;
`ifdef RFILE_BYPASS_EN
      #1 chk("same_cycle rd0", rd[31:0], 32'd42);
`else
      #1 chk("same_cycle rd0", rd[31:0], 32'd0);
`endif
      @(posedge clk); m_clock();
      @(negedge clk); idle();
      #1 chk("after_edge rd0", rd[31:0], 32'd42);
      chk("after_edge rd1", rd[63:32], 32'd42);

      // Random traffic on a narrow address window to force collisions and hazards.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
         iss_v = 1'($urandom_range(0, 1));
         wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
         iss_a = 5'($urandom_range(0, 7));
         wd0 = $urandom; wd1 = $urandom;
         ra0 = 5'($urandom_range(0, 7));
         ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         #1;
         chk("rand rd0", rd[31:0], m_rd(ra0));
         chk("rand rd1", rd[63:32], m_rd(ra1));
         chk("rand rbusy", {30'd0, rbusy}, {30'd0, m_rb(ra1), m_rb(ra0)});
         chk("rand wr_conf", {31'd0, wr_conf}, {31'd0, m_conf});
         @(posedge clk); m_clock();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rfile_sb.md
Name: rfile_sb

Overview:
- Parametrised successor of the core register file: NRD combinational read ports and two synchronous write ports (W0 = ALU writeback, W1 = load writeback).
- Integrated scoreboard: one busy bit per register, for pipeline hazard detection.
- Sits between decode (reads, issue) and writeback; x0 is hardwired zero and never busy.

Parameters:
- REG_W, 5, register address width
- REG_S, 32, number of architectural registers (must be <= 2**REG_W)
- DATA_W, 32, register data width
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ra  in  NRD*REG_W  read addresses; port i at bits [i*REG_W +: REG_W]
- rd  out  NRD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- rbusy  out  NRD  busy bit of the register addressed by ra port i
- we0  in  1  write enable, port 0
- wa0  in  REG_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- wa1  in  REG_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- iss_v  in  1  issue valid: mark iss_a busy
- iss_a  in  REG_W  destination register of the issuing instruction
- wr_conf  out  1  registered flag: same-address dual write occurred last cycle

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately clears all registers, all busy bits and wr_conf to 0, regardless of clk.
  - While rst_n=0, rd is all zeros and rbusy is 0.
  - Reset asserted mid-operation discards any write presented in that cycle.
- Reads:
  - Combinational, zero latency.
  - Address 0 always returns 0 with rbusy=0.
  - Address >= REG_S returns 0 with rbusy=0.
- Writes:
  - Take effect on the rising clk edge.
  - A write to x0 or to an address >= REG_S is ignored.
- Dual-write conflict:
  - Condition: we0 && we1 && wa0==wa1 && wa0!=0.
  - Port 0 data is stored and port 1 is dropped.
  - wr_conf goes to 1 for exactly the following cycle; otherwise wr_conf is 0.
- Scoreboard:
  - On each edge, busy[iss_a] is set if iss_v=1.
  - busy[wa0] is cleared if we0=1; busy[wa1] is cleared if we1=1.
  - Simultaneous set and clear of the same register: set wins, because the newer producer is issuing.
  - iss_v with iss_a=0 has no effect.
  - Setting an already-busy register keeps it busy; no counting.
- Without bypass, a read in the same cycle as a write to that address returns the old value; the new value is visible after the edge.

Optional Feature:
- Macro: RFILE_BYPASS_EN.
- When defined:
  - A read port whose address equals an active write address (nonzero, < REG_S) returns that write data in the same cycle.
  - Port 0 has priority when both write ports match.
  - rbusy for that port reads 0 unless iss_v targets the same register that cycle.
- When undefined:
  - rd is the array contents only.
  - rbusy is the current busy bit only.
  - No added combinational path from the write ports to rd or rbusy.

Decomposition:
- Shared package rfile_pkg holds:
  - default REG_W, DATA_W and REG_S constants;
  - ZERO_REG constant (0);
  - a typedef for the register address;
  - a typedef for the register data word.
- One sub-module, rfile_sboard: the REG_S-bit busy vector with its set/clear priority logic and NRD lookup outputs.
- The data array, write-conflict resolution, bypass muxes and wr_conf remain in rfile_sb.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, release, read ra={1,31} -> rd={0,0}, rbusy=0, wr_conf=0.
- Basic write/read: we0=1, wa0=1, wd0=5; next cycle ra port0=1 -> rd=5. Then write 999 to x0 -> x0 reads 0.
- Conflict: we0=we1=1, wa0=wa1=10, wd0=123, wd1=77 -> x10 reads 123 and wr_conf=1 for one cycle, then 0. Then wa0=3, wa1=4 in the same cycle -> both stored, wr_conf=0.
- Scoreboard: iss_v=1, iss_a=7 -> rbusy=1 at ra=7. Then iss_v=1 with we1=1, wa1=7 in the same cycle -> stays busy. Next cycle we1 alone -> rbusy=0. iss_a=0 -> never busy.
- Mid-operation reset: x2=0xDEAD_BEEF and busy[2]=1; pulse rst_n low between clock edges -> rd=0 and rbusy=0 immediately, with no edge required.
- Same-cycle read/write: we0=1, wa0=5, wd0=42 while ra=5 -> with RFILE_BYPASS_EN rd=42 that cycle; without it rd=old value that cycle and 42 after the edge.
